// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes,
// controller state encoding and the iteration count of the datapath.
package mips_pkg;

    // Operation codes carried on the op input of the multiply/divide unit
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // One datapath iteration per operand bit
    localparam int MD_ITER = 32;

    // Controller states; IDLE and DONE are the states that accept new work
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO
// registers. Operands are reduced to magnitudes at launch, iterated for
// 32 cycles (shift-add or restoring division) and sign-corrected in FIX.
module mult_div_unit
    import mips_pkg::*;
(
    input  logic        Clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busX,
    input  logic [31:0] busY,
    input  logic        mthi_wen,
    input  logic        mtlo_wen,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

    // Two's complement helpers used for magnitude extraction and sign fix-up
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

    function automatic logic [31:0] absVal(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    md_state_e   state_q;
    logic [4:0]  cnt_q;
    logic        opIsDiv_q;
    logic        negRes_q;
    logic        negRem_q;
    logic        divZero_q;
    logic [31:0] dividend_q;
    logic [31:0] addend_q;
    logic [63:0] acc_q;
    logic [32:0] rem_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        startSigned;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [32:0] mulSum_d;
    logic [63:0] mulAcc_d;
    logic [33:0] divDiff_d;
    logic [32:0] remNext_d;
    logic [31:0] quotNext_d;
    logic [63:0] product_d;
    logic [31:0] fixHi_d;
    logic [31:0] fixLo_d;

    // Launch-time operand conditioning: magnitudes for signed ops, raw otherwise
    always_comb begin
        startSigned = ~op[0];
        aMag        = startSigned ? absVal(busX) : busX;
        bMag        = startSigned ? absVal(busY) : busY;
    end

    // One iteration of each datapath: multiplier bits are consumed from
    // acc_q[0] upward, dividend bits are shifted out of acc_q[31] into the
    // partial remainder while quotient bits are shifted in at the bottom
    always_comb begin
        mulSum_d  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, addend_q} : 33'd0);
        mulAcc_d  = {mulSum_d, acc_q[31:1]};
        divDiff_d = {rem_q, acc_q[31]} - {2'b00, addend_q};
        if (divDiff_d[33]) begin
            remNext_d  = {rem_q[31:0], acc_q[31]};
            quotNext_d = {acc_q[30:0], 1'b0};
        end else begin
            remNext_d  = divDiff_d[32:0];
            quotNext_d = {acc_q[30:0], 1'b1};
        end
    end

    // Sign correction of the magnitude result, plus the divide-by-zero override
    always_comb begin
        product_d = negRes_q ? neg64(acc_q) : acc_q;
        fixHi_d   = product_d[63:32];
        fixLo_d   = product_d[31:0];
        if (opIsDiv_q) begin
            if (divZero_q) begin
                fixLo_d = 32'hFFFF_FFFF;
                fixHi_d = dividend_q;
            end else begin
                fixLo_d = negRes_q ? neg32(acc_q[31:0]) : acc_q[31:0];
                fixHi_d = negRem_q ? neg32(rem_q[31:0]) : rem_q[31:0];
            end
        end
    end

    // Controller, datapath registers and HI/LO with registered busy/done
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= 5'd0;
            opIsDiv_q  <= 1'b0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            dividend_q <= 32'd0;
            addend_q   <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 33'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE, MD_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opIsDiv_q  <= op[1];
                        negRes_q   <= startSigned & (busX[31] ^ busY[31]);
                        negRem_q   <= startSigned & busX[31];
                        divZero_q  <= (busY == 32'd0);
                        dividend_q <= busX;
                        addend_q   <= op[1] ? bMag : aMag;
                        acc_q      <= {32'd0, op[1] ? aMag : bMag};
                        rem_q      <= 33'd0;
                        cnt_q      <= 5'd0;
                        busy_q     <= 1'b1;
                        state_q    <= MD_CALC;
                    end else begin
                        if (mthi_wen) begin
                            hi_q <= busX;
                        end
                        if (mtlo_wen) begin
                            lo_q <= busX;
                        end
                        state_q <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (opIsDiv_q) begin
                        rem_q        <= remNext_d;
                        acc_q[31:0]  <= quotNext_d;
                    end else begin
                        acc_q <= mulAcc_d;
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    hi_q    <= fixHi_d;
                    lo_q    <= fixLo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= MD_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model
// tracked every cycle, plus directed scenarios with literal expectations.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busX;
    logic [31:0] busY;
    logic        mthiWen;
    logic        mtloWen;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    // Reference model state, updated at each rising edge
    logic        modelValid = 1'b0;
    logic        expBusy;
    logic        expDone;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic [63:0] pendResult;
    int          remaining;

    mult_div_unit dut (
        .Clk     (clk),
        .rst_n   (rstN),
        .start   (start),
        .op      (op),
        .busX    (busX),
        .busY    (busY),
        .mthi_wen(mthiWen),
        .mtlo_wen(mtloWen),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result {HI,LO} from plain integer arithmetic
    function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_MULT:  p = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == MD_DIVU) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: 34-cycle latency from acceptance, MT writes only while not busy,
    // start has priority over MT writes, reset clears everything
    always @(posedge clk) begin
        if (!rstN) begin
            modelValid = 1'b1;
            expBusy    = 1'b0;
            expDone    = 1'b0;
            expHi      = 32'd0;
            expLo      = 32'd0;
            remaining  = 0;
        end else if (modelValid) begin
            expDone = 1'b0;
            if (expBusy) begin
                remaining--;
                if (remaining == 0) begin
                    expBusy = 1'b0;
                    expDone = 1'b1;
                    expHi   = pendResult[63:32];
                    expLo   = pendResult[31:0];
                end
            end else if (start) begin
                pendResult = refResult(op, busX, busY);
                expBusy    = 1'b1;
                remaining  = 33;
            end else begin
                if (mthiWen) expHi = busX;
                if (mtloWen) expLo = busX;
            end
        end
    end

    // Compare every cycle, shortly after the edge
    always @(posedge clk) begin
        #2;
        if (modelValid) begin
            checkOutput("model_busy", {31'd0, busy}, {31'd0, expBusy});
            checkOutput("model_done", {31'd0, done}, {31'd0, expDone});
            checkOutput("model_hi", hi, expHi);
            checkOutput("model_lo", lo, expLo);
        end
    end

    // Launch an op at the current negedge and wait (bounded) for done.
    // injKind: 0 none, 1 MTHI while busy, 2 start while busy, 3 reset.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int injCycle, input int injKind,
                                 input logic [31:0] holdHi, output int lat, output int busyCnt);
        start   = 1'b1;
        op      = o;
        busX    = a;
        busY    = b;
        lat     = -1;
        busyCnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start   = 1'b0;
                mthiWen = 1'b0;
                mtloWen = 1'b0;
            end
            if (injKind != 0 && i == injCycle) begin
                case (injKind)
                    1: begin mthiWen = 1'b1; busX = 32'hDEAD_BEEF; end
                    2: begin start = 1'b1; op = MD_DIVU; busX = 32'd100; busY = 32'd7; end
                    default: rstN = 1'b0;
                endcase
            end
            if (injKind != 0 && i == injCycle + 1) begin
                mthiWen = 1'b0;
                start   = 1'b0;
                rstN    = 1'b1;
                if (injKind == 3) begin
                    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
                    checkOutput("reset_hi", hi, 32'd0);
                    checkOutput("reset_lo", lo, 32'd0);
                end
            end
            if (injKind == 1 && i == injCycle + 2) begin
                checkOutput("mthi_while_busy", hi, holdHi);
            end
            if (busy) busyCnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic runDirected(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] wantHi,
                               input logic [31:0] wantLo);
        int lat;
        int bc;
        @(negedge clk);
        applyStimulus(o, a, b, 0, 0, 32'd0, lat, bc);
        checkOutput({name, "_latency"}, 32'(lat), 32'd34);
        checkOutput({name, "_hi"}, hi, wantHi);
        checkOutput({name, "_lo"}, lo, wantLo);
    endtask

    // Overall time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int bc;
        rstN    = 1'b0;
        start   = 1'b0;
        op      = MD_MULT;
        busX    = 32'd0;
        busY    = 32'd0;
        mthiWen = 1'b0;
        mtloWen = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("por_busy", {31'd0, busy}, 32'd0);
        checkOutput("por_done", {31'd0, done}, 32'd0);
        checkOutput("por_hi", hi, 32'd0);
        checkOutput("por_lo", lo, 32'd0);
        rstN = 1'b1;

        @(negedge clk);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'd0, lat, bc);
        checkOutput("multu_latency", 32'(lat), 32'd34);
        checkOutput("multu_busy_cycles", 32'(bc), 32'd33);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);

        runDirected("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runDirected("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runDirected("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runDirected("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        runDirected("div_zero", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        runDirected("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runDirected("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Move-to writes, one at a time and then both together
        @(negedge clk);
        mthiWen = 1'b1; busX = 32'h1234_5678;
        @(negedge clk);
        mthiWen = 1'b0;
        checkOutput("mthi", hi, 32'h1234_5678);
        mtloWen = 1'b1; busX = 32'hCAFE_BABE;
        @(negedge clk);
        mtloWen = 1'b0;
        checkOutput("mtlo", lo, 32'hCAFE_BABE);
        checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);

        // MTHI while busy is ignored and the operand is not re-read
        @(negedge clk);
        applyStimulus(MD_MULTU, 32'd3, 32'd5, 5, 1, 32'h1234_5678, lat, bc);
        checkOutput("mthi_busy_hi", hi, 32'd0);
        checkOutput("mthi_busy_lo", lo, 32'd15);

        @(negedge clk);
        mthiWen = 1'b1; mtloWen = 1'b1; busX = 32'h0F0F_0F0F;
        @(negedge clk);
        mthiWen = 1'b0; mtloWen = 1'b0;
        checkOutput("mt_both_hi", hi, 32'h0F0F_0F0F);
        checkOutput("mt_both_lo", lo, 32'h0F0F_0F0F);

        // Start together with MT writes: start wins, MT dropped
        @(negedge clk);
        mthiWen = 1'b1; mtloWen = 1'b1;
        applyStimulus(MD_MULTU, 32'd2, 32'd3, 0, 0, 32'd0, lat, bc);
        checkOutput("start_wins_lo", lo, 32'd6);

        // A second start while busy is ignored
        @(negedge clk);
        applyStimulus(MD_MULT, 32'd6, 32'hFFFF_FFFE, 8, 2, 32'd0, lat, bc);
        checkOutput("start_busy_latency", 32'(lat), 32'd34);
        checkOutput("start_busy_hi", hi, 32'hFFFF_FFFF);
        checkOutput("start_busy_lo", lo, 32'hFFFF_FFF4);

        // Reset in cycle 10 aborts the operation with no done pulse
        @(negedge clk);
        applyStimulus(MD_MULT, 32'd1000, 32'd1000, 10, 3, 32'd0, lat, bc);
        checkOutput("reset_no_done", 32'(lat), 32'hFFFF_FFFF);

        // Back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        applyStimulus(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 0, 32'd0, lat, bc);
        checkOutput("b2b_first_hi", hi, 32'd1);
        checkOutput("b2b_first_lo", lo, 32'd0);
        applyStimulus(MD_DIV, 32'd100, 32'hFFFF_FFF9, 0, 0, 32'd0, lat, bc);
        checkOutput("b2b_latency", 32'(lat), 32'd34);
        checkOutput("b2b_hi", hi, 32'd2);
        checkOutput("b2b_lo", lo, 32'hFFFF_FFF2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
